// File: rtl/hazard_ctrl.sv
// Decode-stage hazard unit: in-flight destination scoreboard, stall/bubble,
// redirect flush and optional forwarding select (enable with HAZ_FWD_EN).
module hazard_ctrl #(
    parameter int REG_AW    = 3,
    parameter int DEPTH     = 3,
    parameter int FLUSH_CYC = 1,
    localparam int FW       = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic              id_rs_use,
    input  logic              id_rt_use,
    input  logic              id_wr,
    input  logic              id_load,
    input  logic              id_redirect,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    output logic              stall,
    output logic              bubble,
    output logic              flush,
    output logic [FW-1:0]     fwd_rs,
    output logic [FW-1:0]     fwd_rt,
    output logic [15:0]       stall_cnt
);

    logic [DEPTH-1:0]  sb_vld;
    logic [DEPTH-1:0]  sb_ld;
    logic [REG_AW-1:0] sb_rd [DEPTH];
    logic [2:0]        fcnt;
    logic              live;
    logic              hazard;
    logic              rs_hit;
    logic              rt_hit;
    logic [FW-1:0]     rs_idx;
    logic [FW-1:0]     rt_idx;
    logic              take_redir;

    assign flush = (fcnt != 3'd0);
    assign live  = id_valid && !flush && !rst;

    // Walk oldest to youngest so the lowest matching index wins.
    always_comb begin
        rs_hit = 1'b0;
        rt_hit = 1'b0;
        rs_idx = '0;
        rt_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (id_rs_use && sb_vld[i] && (sb_rd[i] == id_rs)) begin
                rs_hit = 1'b1;
                rs_idx = FW'(i);
            end
            if (id_rt_use && sb_vld[i] && (sb_rd[i] == id_rt)) begin
                rt_hit = 1'b1;
                rt_idx = FW'(i);
            end
        end
    end

`ifdef HAZ_FWD_EN
    always_comb begin
        hazard = (rs_hit && (rs_idx == '0) && sb_ld[0])
              || (rt_hit && (rt_idx == '0) && sb_ld[0]);
        fwd_rs = '0;
        fwd_rt = '0;
        if (live && !hazard) begin
            if (rs_hit) fwd_rs = rs_idx + FW'(1);
            if (rt_hit) fwd_rt = rt_idx + FW'(1);
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{sb_ld, rs_idx, rt_idx};
    assign hazard     = rs_hit || rt_hit;
    assign fwd_rs     = '0;
    assign fwd_rt     = '0;
`endif

    assign stall      = live && hazard;
    assign bubble     = stall;
    assign take_redir = live && !stall && id_redirect;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_vld <= '0;
            sb_ld  <= '0;
            for (int i = 0; i < DEPTH; i++) sb_rd[i] <= '0;
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                sb_vld[i] <= sb_vld[i-1];
                sb_ld[i]  <= sb_ld[i-1];
                sb_rd[i]  <= sb_rd[i-1];
            end
            sb_vld[0] <= live && !stall && id_wr;
            sb_ld[0]  <= id_load;
            sb_rd[0]  <= id_rd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcnt <= 3'd0;
        end else if (take_redir) begin
            fcnt <= 3'(FLUSH_CYC);
        end else if (fcnt != 3'd0) begin
            fcnt <= fcnt - 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 16'd0;
        end else if (stall && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule
